// File: rtl/boreal_ads_cfg_ctrl.sv
// ADS1299 bring-up sequencer: POR/reset, SDATAC, WREG table, RDATAC, then DRDY watchdog.
// Define BOREAL_CFG_VERIFY_EN to add WREG readback verification (RREG) before RDATAC.
module boreal_ads_cfg_ctrl #(
  parameter int N_REGS       = 24,
  parameter int CLK_DIV      = 8,
  parameter int BYTE_GAP     = 200,
  parameter int T_POR        = 20000,
  parameter int T_RST        = 400,
  parameter int T_SETTLE     = 2000,
  parameter int DRDY_TIMEOUT = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  output logic [$clog2(N_REGS)-1:0] tbl_addr,
  input  logic [7:0]                tbl_data,
  output logic                      sclk,
  output logic                      cs_n,
  output logic                      mosi,
  input  logic                      miso,
  input  logic                      drdy_n,
  output logic                      ads_reset_n,
  output logic                      ads_start,
  output logic                      stream_en,
  output logic                      busy,
  output logic                      cfg_done,
  output logic                      cfg_err,
  output logic [1:0]                err_code
);
  localparam int AW   = $clog2(N_REGS);
  localparam int M1   = (T_POR > T_RST) ? T_POR : T_RST;
  localparam int M2   = (M1 > T_SETTLE) ? M1 : T_SETTLE;
  localparam int TMAX = (M2 > DRDY_TIMEOUT) ? M2 : DRDY_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CMAX = (CLK_DIV > BYTE_GAP) ? CLK_DIV : BYTE_GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_POR, S_RSTLO, S_RSTWT, S_SDATAC, S_WREG,
`ifdef BOREAL_CFG_VERIFY_EN
    S_VERIFY,
`endif
    S_RDATAC, S_STREAM, S_FAULT
  } state_t;

  typedef enum logic [2:0] {PH_OFF, PH_LEAD, PH_BIT, PH_GAP, PH_TAIL} ph_t;

  state_t          r_state, w_nxt;
  ph_t             r_ph;
  logic [TW-1:0]   r_tmr;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_half;
  logic [1:0]      r_byte, w_nbytes;
  logic [AW-1:0]   r_reg;
  logic [7:0]      r_tx, w_byte;
  logic            r_sclk, r_csn, r_mosi;
  logic [1:0]      r_err;
  logic            r_d1, r_d2, r_d3;
  logic            w_frame, w_fdone, w_last_reg, w_fall;
`ifdef BOREAL_CFG_VERIFY_EN
  logic [7:0]      r_rx;
  logic            w_mismatch;
  assign w_mismatch = (r_rx != tbl_data);
`else
  logic            w_unused_miso;
  assign w_unused_miso = miso;
`endif

  assign w_frame = (r_state == S_SDATAC) || (r_state == S_WREG) || (r_state == S_RDATAC)
`ifdef BOREAL_CFG_VERIFY_EN
                   || (r_state == S_VERIFY)
`endif
                   ;
  assign w_fdone    = w_frame && (r_ph == PH_TAIL) && (r_cnt == CW'(CLK_DIV - 1));
  assign w_last_reg = (r_reg == AW'(N_REGS - 1));
  assign w_fall     = r_d3 & ~r_d2;
  assign w_nbytes   = ((r_state == S_SDATAC) || (r_state == S_RDATAC)) ? 2'd1 : 2'd3;

  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      S_SDATAC: w_byte = 8'h11;
      S_RDATAC: w_byte = 8'h10;
      S_WREG: begin
        if (r_byte == 2'd0)      w_byte = 8'h40 | 8'(r_reg);
        else if (r_byte == 2'd2) w_byte = tbl_data;
      end
`ifdef BOREAL_CFG_VERIFY_EN
      S_VERIFY: if (r_byte == 2'd0) w_byte = 8'h20 | 8'(r_reg);
`endif
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cfg_start) w_nxt = S_POR;
      S_POR:    if (r_tmr == TW'(T_POR - 1)) w_nxt = S_RSTLO;
      S_RSTLO:  if (r_tmr == TW'(T_RST - 1)) w_nxt = S_RSTWT;
      S_RSTWT:  if (r_tmr == TW'(T_SETTLE - 1)) w_nxt = S_SDATAC;
      S_SDATAC: if (w_fdone) w_nxt = S_WREG;
`ifdef BOREAL_CFG_VERIFY_EN
      S_WREG:   if (w_fdone && w_last_reg) w_nxt = S_VERIFY;
      S_VERIFY: if (w_fdone) begin
        if (w_mismatch)      w_nxt = S_FAULT;
        else if (w_last_reg) w_nxt = S_RDATAC;
      end
`else
      S_WREG:   if (w_fdone && w_last_reg) w_nxt = S_RDATAC;
`endif
      S_RDATAC: if (w_fdone) w_nxt = S_STREAM;
      // A DRDY edge in the final cycle still rescues the stream.
      S_STREAM: if (!w_fall && r_tmr == TW'(DRDY_TIMEOUT - 1)) w_nxt = S_FAULT;
      S_FAULT:  if (cfg_start) w_nxt = S_POR;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ads_reset_n = (r_state != S_RSTLO);
    ads_start   = (r_state == S_STREAM);
    stream_en   = (r_state == S_STREAM);
    cfg_done    = (r_state == S_STREAM);
    cfg_err     = (r_state == S_FAULT);
    busy        = (r_state != S_IDLE) && (r_state != S_STREAM) && (r_state != S_FAULT);
  end

  assign sclk     = r_sclk;
  assign cs_n     = r_csn;
  assign mosi     = r_mosi;
  assign err_code = r_err;
  assign tbl_addr = r_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
      r_reg <= '0;
      r_err <= 2'd0;
      r_d1  <= 1'b1;
      r_d2  <= 1'b1;
      r_d3  <= 1'b1;
    end else begin
      {r_d3, r_d2, r_d1} <= {r_d2, r_d1, drdy_n};
      if (w_nxt != r_state || (r_state == S_STREAM && w_fall)) r_tmr <= '0;
      else if (r_tmr != TW'(TMAX))                              r_tmr <= r_tmr + 1'b1;
      if (w_nxt != r_state) r_reg <= '0;
      else if (w_fdone)     r_reg <= r_reg + 1'b1;
      if (r_state == S_FAULT && cfg_start)                   r_err <= 2'd0;
      else if (r_state == S_STREAM && w_nxt == S_FAULT)      r_err <= 2'd1;
`ifdef BOREAL_CFG_VERIFY_EN
      else if (r_state == S_VERIFY && w_nxt == S_FAULT)      r_err <= 2'd2;
`endif
    end
  end

  // Byte engine, SPI mode 1: sclk high in the first half of each bit, low in the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph <= PH_OFF; r_cnt <= '0; r_half <= '0; r_byte <= '0; r_tx <= '0;
      r_sclk <= 1'b0; r_csn <= 1'b1; r_mosi <= 1'b0;
`ifdef BOREAL_CFG_VERIFY_EN
      r_rx <= '0;
`endif
    end else if (!w_frame) begin
      r_ph <= PH_OFF; r_sclk <= 1'b0; r_csn <= 1'b1; r_mosi <= 1'b0;
    end else begin
      case (r_ph)
        PH_OFF: begin
          r_ph <= PH_LEAD; r_csn <= 1'b0; r_cnt <= '0; r_byte <= '0;
        end
        PH_LEAD: begin
          if (r_cnt == CW'(CLK_DIV - 1)) begin
            r_ph <= PH_BIT; r_cnt <= '0; r_half <= '0;
            r_sclk <= 1'b1; r_mosi <= w_byte[7]; r_tx <= {w_byte[6:0], 1'b0};
          end else r_cnt <= r_cnt + 1'b1;
        end
        PH_BIT: begin
          if (r_cnt == CW'(CLK_DIV - 1)) begin
            r_cnt <= '0;
            if (r_half == 4'd15) begin
              r_ph <= PH_GAP; r_byte <= r_byte + 1'b1;
            end else begin
              r_half <= r_half + 1'b1;
              if (r_sclk) begin
                r_sclk <= 1'b0;
`ifdef BOREAL_CFG_VERIFY_EN
                r_rx <= {r_rx[6:0], miso};
`endif
              end else begin
                r_sclk <= 1'b1; r_mosi <= r_tx[7]; r_tx <= {r_tx[6:0], 1'b0};
              end
            end
          end else r_cnt <= r_cnt + 1'b1;
        end
        PH_GAP: begin
          if (r_cnt == CW'(BYTE_GAP - 1)) begin
            r_cnt <= '0;
            if (r_byte == w_nbytes) r_ph <= PH_TAIL;
            else begin
              r_ph <= PH_BIT; r_half <= '0;
              r_sclk <= 1'b1; r_mosi <= w_byte[7]; r_tx <= {w_byte[6:0], 1'b0};
            end
          end else r_cnt <= r_cnt + 1'b1;
        end
        PH_TAIL: begin
          if (r_cnt == CW'(CLK_DIV - 1)) begin
            r_ph <= PH_OFF; r_csn <= 1'b1; r_mosi <= 1'b0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        default: r_ph <= PH_OFF;
      endcase
    end
  end
endmodule

// File: tb/tb_boreal_ads_cfg_ctrl.sv
// Directed bench for boreal_ads_cfg_ctrl: bring-up timing, frame decode, watchdog, reset abort.
// The readback section runs only when BOREAL_CFG_VERIFY_EN is defined.
module tb_boreal_ads_cfg_ctrl;
  localparam int NR = 3;

  logic       clk = 1'b0, rst_n = 1'b0, cfg_start = 1'b0, miso = 1'b0, drdy_n = 1'b1;
  logic [1:0] tbl_addr;
  logic [7:0] tbl_data = 8'h00;
  logic       sclk, cs_n, mosi, ads_reset_n, ads_start, stream_en, busy, cfg_done, cfg_err;
  logic [1:0] err_code;

  boreal_ads_cfg_ctrl #(.N_REGS(NR), .CLK_DIV(2), .BYTE_GAP(4), .T_POR(10), .T_RST(5),
                        .T_SETTLE(8), .DRDY_TIMEOUT(50)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .drdy_n(drdy_n),
    .ads_reset_n(ads_reset_n), .ads_start(ads_start), .stream_en(stream_en), .busy(busy),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .err_code(err_code));

  always #5 clk = ~clk;

  logic [7:0] rom [0:3] = '{8'h96, 8'hD0, 8'hEC, 8'h00};
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SPI monitor + ADC readback model, sampled on the falling clk edge.
  logic [7:0] q_bytes[$];
  int         q_flen[$], q_cl[$], q_hi[$];
  logic [7:0] m_sh = 8'h00, m_b0 = 8'h00, rv;
  int         m_bits = 0, m_fb = 0, m_cl = 0, m_hi = 0, m_idle_bad = 0;
  logic       p_sclk = 1'b0, p_csn = 1'b1;
  bit         bad_rd = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_bits = 0; m_fb = 0; m_cl = 0; m_hi = 0; p_sclk = 1'b0; p_csn = 1'b1;
    end else begin
      if (cs_n && sclk) m_idle_bad++;
      if (!cs_n) m_cl++;
      if (sclk) m_hi++;
      if (!p_sclk && sclk && m_fb == 2 && m_b0[7:4] == 4'h2) begin
        rv = (bad_rd && m_b0[1:0] == 2'd1) ? 8'hD1 : rom[m_b0[1:0]];
        miso = rv[3'(7 - m_bits)];
      end
      if (p_sclk && !sclk) begin
        m_sh = {m_sh[6:0], mosi};
        m_bits++;
        if (m_bits == 8) begin
          q_bytes.push_back(m_sh);
          if (m_fb == 0) m_b0 = m_sh;
          m_bits = 0; m_fb++;
        end
      end
      if (!p_csn && cs_n) begin
        q_flen.push_back(m_fb); q_cl.push_back(m_cl); q_hi.push_back(m_hi);
        m_fb = 0; m_cl = 0; m_hi = 0; m_bits = 0;
      end
      p_sclk = sclk; p_csn = cs_n;
    end
  end

  task automatic clr();
    q_bytes.delete(); q_flen.delete(); q_cl.delete(); q_hi.delete(); m_idle_bad = 0;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1; @(negedge clk); cfg_start = 1'b0;
  endtask

  typedef struct {
    int         nb;
    logic [7:0] b0, b1, b2;
    int         cslow;
  } frm_t;
  frm_t exp_f [5];

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, k, fl;
    logic [7:0] eb, ab;
    exp_f[0] = '{nb: 1, b0: 8'h11, b1: 8'h00, b2: 8'h00, cslow: 40};
    exp_f[1] = '{nb: 3, b0: 8'h40, b1: 8'h00, b2: 8'h96, cslow: 112};
    exp_f[2] = '{nb: 3, b0: 8'h41, b1: 8'h00, b2: 8'hD0, cslow: 112};
    exp_f[3] = '{nb: 3, b0: 8'h42, b1: 8'h00, b2: 8'hEC, cslow: 112};
    exp_f[4] = '{nb: 1, b0: 8'h10, b1: 8'h00, b2: 8'h00, cslow: 40};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // {sclk,cs_n,mosi,ads_reset_n,ads_start,stream_en,busy,cfg_done,cfg_err,err_code,tbl_addr}
    chk("reset_outs", {sclk, cs_n, mosi, ads_reset_n, ads_start, stream_en, busy, cfg_done,
                       cfg_err, err_code, tbl_addr}, 13'b0_1_0_1_0_0_0_0_0_00_00);

    clr();
    pulse_start();
    chk("busy_after_start", busy, 1'b1);
    n = 0; while (ads_reset_n && n < 100) begin @(negedge clk); n++; end
    chk("por_cycles", n, 10);
    n = 0; while (!ads_reset_n && n < 100) begin @(negedge clk); n++; end
    chk("rst_low_cycles", n, 5);
    // T_SETTLE wait, then one cs_n-high cycle before the frame opens.
    n = 0; while (cs_n && n < 100) begin @(negedge clk); n++; end
    chk("settle_to_cs", n, 9);

    n = 0; while (q_bytes.size() < 5 && n < 3000) begin @(negedge clk); n++; end
    pulse_start();
    n = 0; while (!cfg_done && n < 3000) begin @(negedge clk); n++; end
    chk("reach_stream", cfg_done, 1'b1);
    chk("stream_outs", {stream_en, ads_start, busy, cs_n, sclk, mosi, cfg_err},
        7'b1_1_0_1_0_0_0);

    chk("frame_count", q_flen.size(), 5);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      fl = (i < q_flen.size()) ? q_flen[i] : -1;
      chk($sformatf("frame%0d_len", i), fl, exp_f[i].nb);
      chk($sformatf("frame%0d_cslow", i), (i < q_cl.size()) ? q_cl[i] : -1, exp_f[i].cslow);
      chk($sformatf("frame%0d_sclkhi", i), (i < q_hi.size()) ? q_hi[i] : -1, 16 * exp_f[i].nb);
      for (int j = 0; j < exp_f[i].nb; j++) begin
        eb = (j == 0) ? exp_f[i].b0 : (j == 1) ? exp_f[i].b1 : exp_f[i].b2;
        ab = (k < q_bytes.size()) ? q_bytes[k] : 8'hxx;
        chk($sformatf("frame%0d_byte%0d", i, j), ab, eb);
        k++;
      end
    end
    chk("sclk_idle_low", m_idle_bad, 0);

    // 40-cycle DRDY period keeps the 50-cycle watchdog fed; cfg_start in STREAM is ignored.
    k = 0;
    for (int p = 0; p < 20; p++) begin
      drdy_n = 1'b0; repeat (4) @(negedge clk);
      drdy_n = 1'b1; repeat (36) @(negedge clk);
      if (p == 10) pulse_start();
      if (cfg_done) k++;
    end
    chk("stream_alive", k, 20);
    // Synchronizer + edge detect add 3 cycles before the watchdog clears.
    n = 40; while (cfg_done && n < 200) begin @(negedge clk); n++; end
    chk("wdog_cycles", n, 53);
    chk("fault_outs", {stream_en, ads_start, cfg_err, err_code, busy, cfg_done},
        7'b0_0_1_01_0_0);
    clr();
    pulse_start();
    chk("restart_clears", {cfg_err, err_code, busy}, 4'b0_00_1);

    n = 0; while (!(q_bytes.size() == 2 && sclk) && n < 3000) begin @(negedge clk); n++; end
    chk("midframe_hit", q_bytes.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("midframe_rst", {cs_n, sclk, busy, cfg_done, mosi, ads_reset_n}, 6'b1_0_0_0_0_1);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    chk("idle_after_rst", {busy, cs_n, cfg_err, sclk}, 4'b0_1_0_0);

`ifdef BOREAL_CFG_VERIFY_EN
    clr(); bad_rd = 1'b0;
    pulse_start();
    n = 0; while (!cfg_done && !cfg_err && n < 5000) begin @(negedge clk); n++; end
    chk("verify_ok_stream", {cfg_done, cfg_err}, 2'b10);
    chk("verify_ok_frames", q_flen.size(), 8);

    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    clr(); bad_rd = 1'b1;
    pulse_start();
    n = 0; while (!cfg_err && n < 5000) begin @(negedge clk); n++; end
    chk("verify_bad_fault", {cfg_err, err_code, stream_en}, 4'b1_10_0);
    chk("verify_bad_frames", q_flen.size(), 6);
    k = 0;
    for (int i = 0; i < q_bytes.size(); i++) if (q_bytes[i] == 8'h10) k++;
    chk("verify_no_rdatac", k, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/boreal_ads_cfg_ctrl.md
Name: boreal_ads_cfg_ctrl

Overview:
Power-up and configuration sequencer for the ADS1299 daisy chain. It owns the SPI bus during bring-up and applies the hardware reset. It halts continuous-read mode, writes the register table with WREG commands, re-enters RDATAC and asserts START. It then hands the bus to the streaming SPI chain, watches DRDY for stalls and drops back to a fault state on timeout.

Parameters:
N_REGS, 24, registers written per sequence, at table addresses 0..N_REGS-1 and ADC addresses 0x00..N_REGS-1
CLK_DIV, 8, clk cycles per SCLK half-period during config (SCLK = clk/(2*CLK_DIV))
BYTE_GAP, 200, idle clk cycles between bytes with cs_n held low (covers ADS 4·tCLK decode time)
T_POR, 20000, clk cycles from leaving IDLE to releasing reset
T_RST, 400, clk cycles ads_reset_n is held low
T_SETTLE, 2000, clk cycles after reset release before the first command
DRDY_TIMEOUT, 100000, maximum clk cycles between DRDY falling edges while streaming

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  single-cycle pulse; starts the sequence from IDLE or FAULT
tbl_addr  out  $clog2(N_REGS)  register-table read address
tbl_data  in  8  table data, valid 1 cycle after tbl_addr (sync ROM)
sclk  out  1  config SCLK
cs_n  out  1  config chip select
mosi  out  1  config MOSI
miso  in  1  ADC MISO, used for readback only
drdy_n  in  1  raw ADC DRDY, asynchronous
ads_reset_n  out  1  ADC hardware reset pin
ads_start  out  1  ADC START pin
stream_en  out  1  1 = external mux gives the SPI bus to the streaming chain
busy  out  1  high in every state except IDLE, STREAM and FAULT
cfg_done  out  1  high while in STREAM
cfg_err  out  1  sticky, high in FAULT
err_code  out  2  0 none, 1 DRDY timeout, 2 readback mismatch

Behaviour:
- Reset values: sclk=0, cs_n=1, mosi=0, ads_reset_n=1, ads_start=0, stream_en=0, busy=0, cfg_done=0, cfg_err=0, err_code=0, tbl_addr=0, state=IDLE.
- drdy_n: 2-flop synchronizer, reset to 1. Falling edge is detected from the synchronized value.
- Byte engine:
  - SPI mode 1, MSB first.
  - mosi updates on each SCLK rising edge; miso is sampled on each SCLK falling edge.
  - 8 bits take 16·CLK_DIV cycles, followed by BYTE_GAP idle cycles.
  - sclk returns to 0 after every byte.
- Frame: cs_n falls CLK_DIV cycles before the first SCLK edge. cs_n rises CLK_DIV cycles after the last gap of the frame.
- States and transitions:
  - IDLE: on cfg_start, go to POR_WAIT.
  - POR_WAIT: wait T_POR cycles, then RST_LO.
  - RST_LO: ads_reset_n=0 for T_RST cycles, then RST_WAIT.
  - RST_WAIT: wait T_SETTLE cycles, then SDATAC.
  - SDATAC: one frame sending 0x11, then WREG.
  - WREG, per register i (0..N_REGS-1): one frame sending 0x40|i, then 0x00, then tbl_data[i].
    - tbl_addr is presented at least 2 cycles before the data byte loads.
    - After i = N_REGS-1, go to VERIFY if enabled, else RDATAC.
  - RDATAC: one frame sending 0x10, then STREAM.
  - STREAM:
    - ads_start=1, stream_en=1, cfg_done=1.
    - This block drives sclk=0, cs_n=1, mosi=0.
    - Watchdog counter clears on every DRDY falling edge.
    - When the counter reaches DRDY_TIMEOUT, go to FAULT with err_code=1.
  - FAULT: ads_start=0, stream_en=0, cfg_err=1. cfg_start clears cfg_err/err_code and goes to POR_WAIT.
- cfg_start is ignored in every state other than IDLE and FAULT.
- stream_en and ads_start change only on state entry or exit. There are no glitches and no overlap with config traffic.
- The watchdog starts at 0 on STREAM entry, so the first DRDY also gets the full DRDY_TIMEOUT.
- Counters saturate; none wrap.
- rst_n asserted mid-frame: all outputs go to reset values immediately, no frame completion.

Optional Feature:
- Macro: BOREAL_CFG_VERIFY_EN.
- Defined:
  - VERIFY state after WREG.
  - Per register: one frame sending 0x20|i, 0x00, then 0x00 while 8 miso bits are captured.
  - Captured byte is compared with tbl_data[i]. A mismatch goes to FAULT with err_code=2, stopping at the first failing index. All matching goes to RDATAC.
- Undefined:
  - The VERIFY state and comparator are absent; miso is unused.
  - WREG goes directly to RDATAC.
  - err_code=2 is never produced.

Test Plan:
- Bench params: CLK_DIV=2, BYTE_GAP=4, T_POR=10, T_RST=5, T_SETTLE=8, N_REGS=3, table {0x96,0xD0,0xEC}, DRDY_TIMEOUT=50.
- Reset release → all outputs at reset values. A cfg_start pulse → busy rises next cycle, ads_reset_n low exactly 5 cycles after POR_WAIT ends.
- Full sequence, decoded MOSI frames → 0x11 | 0x40,0x00,0x96 | 0x41,0x00,0xD0 | 0x42,0x00,0xEC | 0x10. Each byte lasts 32 clk with sclk idle low, then stream_en=ads_start=cfg_done=1.
- STREAM, drdy_n toggled every 40 cycles for 20 periods → stays in STREAM. Then drdy_n stalls high → at cycle 50 after the last edge: stream_en=0, cfg_err=1, err_code=1. A cfg_start then restarts the sequence and clears cfg_err.
- VERIFY_EN, ADC model echoes written values → reaches STREAM. Model returns 0xD1 for reg 1 → FAULT with err_code=2, no RDATAC frame sent.
- rst_n asserted mid-way through WREG byte 2 → cs_n=1, sclk=0 and state=IDLE on the same edge. cfg_start with no reset → ignored while busy.
